// File: rtl/alarm_ctrl_pkg.sv
// Shared definitions for the alarm controller: state encoding, the alarm-set UI mode
// and the width of the seconds timer.
package alarm_ctrl_pkg;

    typedef enum logic [1:0] {
        StDisarmed = 2'd0,
        StArmed    = 2'd1,
        StRinging  = 2'd2,
        StSnooze   = 2'd3
    } alarm_state_e;

    localparam logic [3:0]  MODE_ALARM_SET = 4'b0101;
    localparam int unsigned TIMER_W        = 9;
    localparam int unsigned TIMER_MAX      = (1 << TIMER_W) - 1;

endpackage

// File: rtl/alarm_sec_timer.sv
// Loadable seconds down-counter shared by the ringing and snooze phases.
// done pulses on the tick that takes the count from 1 to 0.
module alarm_sec_timer
    import alarm_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               tick,
    output logic               done
);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (tick && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = tick && (count_q == TIMER_W'(1));

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: arms, rings on a fresh time match, auto-dismisses after RING_SECS ticks.
// Define ALARM_SNOOZE_EN to enable the snooze button (NUM_SYNC[0]) and the SNOOZE state.
module alarm_ctrl
    import alarm_ctrl_pkg::*;
#(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned SNOOZE_MAX  = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       TICK_1HZ,
    input  logic       MERIDIEM,
    input  logic [6:0] HOUR,
    input  logic [6:0] MIN,
    input  logic [6:0] SEC,
    input  logic       A_MERIDIEM,
    input  logic [6:0] A_HOUR,
    input  logic [6:0] A_MIN,
    input  logic [6:0] A_SEC,
    input  logic       ALARM_EN,
    input  logic [3:0] MODE,
    input  logic [3:0] NUM_SYNC,
    output logic [1:0] STATE,
    output logic       RING,
    output logic       BUZZ,
    output logic [1:0] SNOOZE_CNT
);

    if (RING_SECS == 0 || RING_SECS > TIMER_MAX) begin : g_bad_ring_secs
        $error("RING_SECS must be in 1..511");
    end
    if (SNOOZE_SECS == 0 || SNOOZE_SECS > TIMER_MAX) begin : g_bad_snooze_secs
        $error("SNOOZE_SECS must be in 1..511");
    end
    // SNOOZE_CNT is two bits wide, so the cap cannot exceed 3.
    if (SNOOZE_MAX == 0 || SNOOZE_MAX > 3) begin : g_bad_snooze_max
        $error("SNOOZE_MAX must be in 1..3");
    end

    alarm_state_e       state_q;
    logic               match, match_q, trigger, beat_q;
    logic               snooze_req, dismiss;
    logic               go_ring, go_snooze, go_armed;
    logic               tmr_load, tmr_tick, tmr_done;
    logic [TIMER_W-1:0] tmr_load_val;
    logic               unused_num;

    assign unused_num = ^NUM_SYNC[2:1];

    assign match   = (MERIDIEM == A_MERIDIEM) && (HOUR == A_HOUR) &&
                     (MIN == A_MIN) && (SEC == A_SEC);
    assign trigger = match && !match_q && (MODE != MODE_ALARM_SET);

`ifdef ALARM_SNOOZE_EN
    localparam logic [1:0] SnoozeMax = 2'(SNOOZE_MAX);
    logic [1:0] snooze_cnt_q;
    assign snooze_req = NUM_SYNC[0] && !NUM_SYNC[3] && (snooze_cnt_q < SnoozeMax);
    assign SNOOZE_CNT = snooze_cnt_q;
`else
    assign snooze_req = 1'b0;
    assign SNOOZE_CNT = 2'b00;
`endif

    // A snooze press with no snoozes left counts as a dismiss.
    assign dismiss = NUM_SYNC[3] || (NUM_SYNC[0] && !snooze_req);

    always_comb begin
        go_ring   = 1'b0;
        go_snooze = 1'b0;
        go_armed  = 1'b0;
        unique case (state_q)
            StDisarmed: ;
            StArmed:    go_ring = trigger;
            StRinging: begin
                if (snooze_req)                go_snooze = 1'b1;
                else if (dismiss || tmr_done)  go_armed  = 1'b1;
            end
            StSnooze: begin
                if (NUM_SYNC[3])               go_armed  = 1'b1;
                else if (tmr_done)             go_ring   = 1'b1;
            end
        endcase
    end

    assign tmr_load     = go_ring || go_snooze;
    assign tmr_load_val = go_snooze ? TIMER_W'(SNOOZE_SECS) : TIMER_W'(RING_SECS);
    assign tmr_tick     = TICK_1HZ && ((state_q == StRinging) || (state_q == StSnooze));

    alarm_sec_timer u_timer (
        .clk      (CLK),
        .rst      (RESET),
        .clr      (!ALARM_EN),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .tick     (tmr_tick),
        .done     (tmr_done)
    );

    // match_q resets high so a match already present at reset release is not an edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StDisarmed;
            beat_q  <= 1'b0;
            match_q <= 1'b1;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_q <= 2'b00;
`endif
        end else begin
            match_q <= match;
            if (!ALARM_EN) begin
                state_q <= StDisarmed;
                beat_q  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                snooze_cnt_q <= 2'b00;
`endif
            end else begin
                if (TICK_1HZ) beat_q <= !beat_q;
                if (state_q == StDisarmed) begin
                    state_q <= StArmed;
                end else if (go_ring) begin
                    state_q <= StRinging;
                    beat_q  <= 1'b1;
                end else if (go_snooze) begin
                    state_q <= StSnooze;
`ifdef ALARM_SNOOZE_EN
                    snooze_cnt_q <= snooze_cnt_q + 2'd1;
`endif
                end else if (go_armed) begin
                    state_q <= StArmed;
`ifdef ALARM_SNOOZE_EN
                    snooze_cnt_q <= 2'b00;
`endif
                end
            end
        end
    end

    assign STATE = state_q;
    assign RING  = (state_q == StRinging);
    assign BUZZ  = RING && beat_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a tick-counting reference model.
module tb_alarm_ctrl;

    localparam int RING_T = 60;
    localparam int SNZ_T  = 300;
    localparam int SNZ_MX = 3;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_ON = 1'b1;
`else
    localparam bit SNZ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, tick, mer, a_mer, en;
    logic [6:0] hr, mn, sc, a_hr, a_mn, a_sc;
    logic [3:0] mode, num;
    logic [1:0] state, snz_cnt;
    logic       ring, buzz;
    logic [5:0] dut_vec;

    int checks = 0;
    int errors = 0;

    // Reference model: phase (0 off, 1 armed, 2 ringing, 3 snoozing), ticks elapsed in phase.
    int m_st, m_el, m_snz;
    bit m_beat, m_prev;

    always #5 clk = ~clk;

    alarm_ctrl dut (
        .CLK        (clk),
        .RESET      (rst),
        .TICK_1HZ   (tick),
        .MERIDIEM   (mer),
        .HOUR       (hr),
        .MIN        (mn),
        .SEC        (sc),
        .A_MERIDIEM (a_mer),
        .A_HOUR     (a_hr),
        .A_MIN      (a_mn),
        .A_SEC      (a_sc),
        .ALARM_EN   (en),
        .MODE       (mode),
        .NUM_SYNC   (num),
        .STATE      (state),
        .RING       (ring),
        .BUZZ       (buzz),
        .SNOOZE_CNT (snz_cnt)
    );

    assign dut_vec = {state, ring, buzz, snz_cnt};

    function automatic logic [5:0] exp_vec();
        return {2'(m_st), m_st == 2, (m_st == 2) && m_beat, 2'(m_snz)};
    endfunction

    task automatic model_step();
        bit match, trig, nb;
        match = (mer == a_mer) && (hr == a_hr) && (mn == a_mn) && (sc == a_sc);
        trig  = match && !m_prev && (mode != 4'b0101);
        if (rst) begin
            m_st = 0; m_el = 0; m_snz = 0; m_beat = 0; m_prev = 1;
            return;
        end
        m_prev = match;
        if (!en) begin
            m_st = 0; m_el = 0; m_snz = 0; m_beat = 0;
            return;
        end
        nb = tick ? !m_beat : m_beat;
        case (m_st)
            0: m_st = 1;
            1: if (trig) begin m_st = 2; m_el = 0; nb = 1; end
            2: begin
                if (num[0] && !num[3] && SNZ_ON && m_snz < SNZ_MX) begin
                    m_st = 3; m_snz++; m_el = 0;
                end else if (num[3] || num[0]) begin
                    m_st = 1; m_snz = 0;
                end else if (tick) begin
                    m_el++;
                    if (m_el == RING_T) begin m_st = 1; m_snz = 0; end
                end
            end
            default: begin
                if (num[3]) begin
                    m_st = 1; m_snz = 0;
                end else if (tick) begin
                    m_el++;
                    if (m_el == SNZ_T) begin m_st = 2; m_el = 0; nb = 1; end
                end
            end
        endcase
        m_beat = nb;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end
    endtask

    task automatic set_time(input logic m, input int h, input int mi, input int s);
        mer = m; hr = 7'(h); mn = 7'(mi); sc = 7'(s);
    endtask

    // Fresh rising edge onto the 07:00:00 AM alarm.
    task automatic fire();
        set_time(1'b0, 6, 59, 59); step();
        set_time(1'b0, 7, 0, 0);   step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; tick = 1'b0; num = 4'd0; mode = 4'd0;
        a_mer = 1'b0; a_hr = 7'd7; a_mn = 7'd0; a_sc = 7'd0;
        set_time(1'b0, 7, 0, 0);
        step(); step();
        checks++;
        if (dut_vec !== 6'd0) begin
            errors++; $display("FAIL reset_state got=%b want=%b", dut_vec, 6'd0);
        end
        rst = 1'b0;
    endtask

    task automatic test_ring_timeout();
        en = 1'b1;
        set_time(1'b0, 6, 59, 59); step(); step();
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL armed got=%0d want=1", state); end
        set_time(1'b0, 7, 0, 0); step();
        checks++;
        if ({state, ring, buzz} !== 4'b1011) begin
            errors++; $display("FAIL ring_start got=%b want=1011", {state, ring, buzz});
        end
        tick_n(59);
        checks++;
        if ({state, ring} !== 3'b101) begin
            errors++; $display("FAIL ring_59 got=%b want=101", {state, ring});
        end
        tick_n(1);
        checks++;
        if ({state, ring, snz_cnt} !== 5'b01000) begin
            errors++; $display("FAIL ring_timeout got=%b want=01000", {state, ring, snz_cnt});
        end
    endtask

    task automatic test_button_vs_timeout();
        fire();
        checks++;
        if (state !== 2'd2) begin errors++; $display("FAIL refire got=%0d want=2", state); end
        tick_n(59);
        tick = 1'b1; num = 4'b1000; step();
        tick = 1'b0; num = 4'b0000;
        checks++;
        if ({state, ring, snz_cnt} !== 5'b01000) begin
            errors++; $display("FAIL btn_vs_tick got=%b want=01000", {state, ring, snz_cnt});
        end
        tick_n(5);
        checks++;
        if (dut_vec !== exp_vec() || state !== 2'd1) begin
            errors++; $display("FAIL no_extra_ring got=%b want=%b", dut_vec, exp_vec());
        end
    endtask

    task automatic test_snooze();
        fire();
`ifdef ALARM_SNOOZE_EN
        for (int k = 1; k <= 3; k++) begin
            num = 4'b0001; step(); num = 4'b0000;
            checks++;
            if ({state, snz_cnt} !== {2'd3, 2'(k)}) begin
                errors++; $display("FAIL snooze_%0d got=%b want=%b", k, {state, snz_cnt},
                                   {2'd3, 2'(k)});
            end
            tick_n(299);
            checks++;
            if (state !== 2'd3) begin errors++; $display("FAIL snz_299 got=%0d want=3", state); end
            tick_n(1);
            checks++;
            if ({state, buzz, snz_cnt} !== {2'd2, 1'b1, 2'(k)}) begin
                errors++; $display("FAIL rering_%0d got=%b want=%b", k, {state, buzz, snz_cnt},
                                   {2'd2, 1'b1, 2'(k)});
            end
        end
`endif
        num = 4'b0001; step(); num = 4'b0000;
        checks++;
        if ({state, snz_cnt} !== 4'b0100) begin
            errors++; $display("FAIL snooze_cap_dismiss got=%b want=0100", {state, snz_cnt});
        end
    endtask

    task automatic test_mode_edit();
        set_time(1'b0, 6, 59, 59); step();
        mode = 4'b0101;
        set_time(1'b0, 7, 0, 0); step(); step();
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL mode_edit got=%0d want=1", state); end
        mode = 4'b0000; step(); step(); step();
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL held_match got=%0d want=1", state); end
    endtask

    task automatic test_disable();
        fire();
        if (SNZ_ON) begin
            num = 4'b0001; step(); num = 4'b0000;
            tick_n(3);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL pre_disable got=%b want=%b", dut_vec, exp_vec());
        end
        en = 1'b0; step();
        checks++;
        if ({state, ring, buzz, snz_cnt} !== 6'd0) begin
            errors++; $display("FAIL disable got=%b want=000000", dut_vec);
        end
        en = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL reenable got=%0d want=1", state); end
    endtask

    task automatic test_reset_mid_ring();
        fire();
        tick_n(3);
        checks++;
        if (ring !== 1'b1) begin errors++; $display("FAIL pre_reset_ring got=%b want=1", ring); end
        rst = 1'b1; step();
        checks++;
        if ({state, ring, buzz} !== 4'b0000) begin
            errors++; $display("FAIL reset_ring got=%b want=0000", {state, ring, buzz});
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL post_reset got=%0d want=1", state); end
    endtask

    task automatic test_random();
        bit at_alarm = 1'b0;
        a_mer = 1'b1; a_hr = 7'd3; a_mn = 7'd15; a_sc = 7'd30;
        for (int i = 0; i < 6000; i++) begin
            rst  = ($urandom_range(0, 499) == 0);
            en   = ($urandom_range(0, 199) != 0);
            tick = 1'($urandom_range(0, 1));
            num  = ($urandom_range(0, 39) == 0) ? 4'($urandom) : 4'd0;
            mode = ($urandom_range(0, 9) == 0) ? 4'b0101 : 4'($urandom_range(0, 4));
            if ($urandom_range(0, 15) == 0) at_alarm = !at_alarm;
            if (at_alarm) set_time(1'b1, 3, 15, 30);
            else          set_time(1'b1, 3, 15, 29);
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random_%0d got=%b want=%b", i, dut_vec, exp_vec());
            end
        end
        rst = 1'b0; en = 1'b1; tick = 1'b0; num = 4'd0; mode = 4'd0;
    endtask

    initial begin
        test_reset();
        test_ring_timeout();
        test_button_vs_timeout();
        test_snooze();
        test_mode_edit();
        test_disable();
        test_reset_mid_ring();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 The block SHALL have parameter RING_SECS, default 60: seconds the alarm rings before auto-dismiss.
REQ-002 The block SHALL have parameter SNOOZE_SECS, default 300: seconds spent in snooze before re-ringing.
REQ-003 The block SHALL have parameter SNOOZE_MAX, default 3: maximum snoozes per alarm event.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port TICK_1HZ, input, 1 bit: one-CLK pulse per second.
REQ-007 The block SHALL have ports MERIDIEM, HOUR[6:0], MIN[6:0] and SEC[6:0], inputs: the current time (HOUR 0..11, binary).
REQ-008 The block SHALL have ports A_MERIDIEM, A_HOUR[6:0], A_MIN[6:0] and A_SEC[6:0], inputs: the alarm time from the alarm-set block.
REQ-009 The block SHALL have port ALARM_EN, input, 1 bit: alarm armed when 1.
REQ-010 The block SHALL have port MODE, input, 4 bits: current UI mode; 4'b0101 = alarm-set mode.
REQ-011 The block SHALL have port NUM_SYNC, input, 4 bits: one-CLK synchronized button pulses.
REQ-012 The block SHALL have port STATE, output, 2 bits: 0 DISARMED, 1 ARMED, 2 RINGING, 3 SNOOZE.
REQ-013 The block SHALL have port RING, output, 1 bit: high while STATE==RINGING.
REQ-014 The block SHALL have port BUZZ, output, 1 bit: RING gated by a beat bit that toggles on each TICK_1HZ.
REQ-015 The block SHALL have port SNOOZE_CNT, output, 2 bits: number of snoozes taken in the current event.

Function
REQ-016 The block SHALL register a MATCH flag each cycle; MATCH = all four current fields equal their alarm fields.
REQ-017 The block SHALL define TRIGGER as MATCH=1, previous MATCH=0, and MODE!=4'b0101 (rising edge only; no trigger while the alarm is being edited).
REQ-018 In DISARMED, the block SHALL go to ARMED in the cycle after ALARM_EN=1.
REQ-019 ALARM_EN=0 SHALL force DISARMED from any state on the next edge; this has the highest priority below RESET; the timer, SNOOZE_CNT and beat clear.
REQ-020 On TRIGGER, ARMED SHALL go to RINGING, with the timer loaded to RING_SECS and the beat set to 1, so that BUZZ=1 in the first RINGING cycle.
REQ-021 RINGING and SNOOZE SHALL ignore TRIGGER.
REQ-022 In RINGING, the timer SHALL decrement on each TICK_1HZ; at timer==1 with a tick, the block SHALL go to ARMED (ring length = RING_SECS ticks).
REQ-023 In RINGING, a NUM_SYNC[3] pulse SHALL dismiss the alarm: go to ARMED and clear SNOOZE_CNT.
REQ-024 When a button pulse and the timeout occur in the same cycle, the button SHALL win.
REQ-025 A button pulse, TICK_1HZ and ALARM_EN=0 in the same cycle SHALL resolve to DISARMED.
REQ-026 Leaving RINGING for ARMED by any path SHALL clear SNOOZE_CNT.
REQ-027 A MATCH that is still held when the block returns to ARMED SHALL NOT retrigger; a new TRIGGER requires a fresh rising edge.
REQ-028 The timer SHALL be 9 bits wide; the block SHALL reject at elaboration any parameter value that exceeds 511 or equals 0.

Reset
REQ-029 On RESET=1 at a CLK edge, the block SHALL set STATE=DISARMED, RING=0, BUZZ=0, SNOOZE_CNT=0, timer=0, beat=0 and MATCH history=1, so that no trigger fires on the first cycle after reset.
REQ-030 RESET asserted mid-ring SHALL silence RING and BUZZ on that same edge.

Configuration
REQ-031 When macro ALARM_SNOOZE_EN is defined, a NUM_SYNC[0] pulse in RINGING with SNOOZE_CNT<SNOOZE_MAX SHALL go to SNOOZE, increment SNOOZE_CNT and load the timer to SNOOZE_SECS.
REQ-032 With ALARM_SNOOZE_EN defined, NUM_SYNC[0] with SNOOZE_CNT==SNOOZE_MAX SHALL act as a dismiss.
REQ-033 With ALARM_SNOOZE_EN defined, SNOOZE SHALL count ticks and, at expiry, return to RINGING with a RING_SECS reload; NUM_SYNC[3] in SNOOZE SHALL dismiss to ARMED.
REQ-034 Without ALARM_SNOOZE_EN, SNOOZE SHALL be unreachable, NUM_SYNC[0] SHALL act as a dismiss, and SNOOZE_CNT SHALL be tied to 0.

Structure
REQ-035 A shared package SHALL hold the state encoding, the constant MODE_ALARM_SET=4'b0101, and the timer width.
REQ-036 The block SHALL use one sub-module, alarm_sec_timer: a loadable 9-bit down-counter with tick enable and a done pulse, shared by the RINGING and SNOOZE states.

Verification
REQ-037 Test: ALARM_EN=1; time 06:59:59 AM steps to the alarm 07:00:00 AM -> next cycle STATE=RINGING and RING=1; after 60 ticks STATE=ARMED.
REQ-038 Test: RINGING, then NUM_SYNC=4'b1000 in the same cycle as the final tick -> ARMED, SNOOZE_CNT=0, no extra ring.
REQ-039 Test (ALARM_SNOOZE_EN defined): snooze 3 times -> SNOOZE_CNT=3, each re-ring 300 ticks after its snooze; a 4th NUM_SYNC[0] -> ARMED.
REQ-040 Test: MODE=4'b0101 while the time crosses the alarm -> STATE stays ARMED.
REQ-041 Test: ALARM_EN dropped mid-SNOOZE -> next cycle DISARMED, SNOOZE_CNT=0; re-enabled with MATCH still true -> no ring.
REQ-042 Test: RESET pulsed during RINGING -> RING=0 on that edge; no trigger on the first cycle after reset even if MATCH=1.
